issue_dispatcher: RTL and testbench

//  In-order dual-issue queue feeding the execution stage. It buffers decoded ops (to_execution) from rename.

---
 rtl/issue_pkg.sv | 26 ++
 rtl/issue_dispatcher_if.sv | 23 ++
 rtl/issue_select.sv | 25 ++
 rtl/issue_dispatcher.sv | 133 +++++++++++++
 tb/tb_issue_dispatcher.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/issue_pkg.sv
// Shared types for the dual-issue dispatcher: FU encodings, the op record sent to execution,
// and the selection result. to_execution mirrors the execution-stage record.
package issue_pkg;

   localparam int ROB_IDX_W = 3;
   localparam int PAYLOAD_W = 16;

   localparam logic [1:0] FU_LSU = 2'b00;
   localparam logic [1:0] FU_FPU = 2'b01;
   localparam logic [1:0] FU_INT = 2'b10;
   localparam logic [1:0] FU_BR  = 2'b11;

   typedef struct packed {
      logic                 valid;
      logic [1:0]           functional_unit;
      logic [ROB_IDX_W-1:0] rob_idx;
      logic [PAYLOAD_W-1:0] payload;
   } to_execution;

   typedef struct packed {
      logic       c0_v;
      logic       c1_v;
      logic [1:0] n;
   } issue_sel_t;

endpackage

// File: rtl/issue_dispatcher_if.sv
// Rename-to-execution bundle: enqueue lanes, flush, FU busy vector and the two issue slots.
// The dispatcher uses the slave modport; its environment uses master.
interface issue_dispatcher_if #(
   parameter int FU_NUMBER = 4
);
   logic [1:0]                      in_valid;
   issue_pkg::to_execution [1:0]    in_data;
   logic                            in_ready;
   logic                            flush;
   logic [FU_NUMBER-1:0]            busy_fu;
   issue_pkg::to_execution [1:0]    t_execution;
   logic [1:0]                      issue_count;

   modport master (
      output in_valid, in_data, flush, busy_fu,
      input  in_ready, t_execution, issue_count
   );

   modport slave (
      input  in_valid, in_data, flush, busy_fu,
      output in_ready, t_execution, issue_count
   );
endinterface

// File: rtl/issue_select.sv
// In-order pair selection: the older candidate must find its FU free, the younger one
// additionally needs the older to issue and a different, free FU.
module issue_select
   import issue_pkg::*;
#(
   parameter int FU_NUMBER = 4
) (
   input  to_execution          i_c0,
   input  logic                 i_c0_present,
   input  to_execution          i_c1,
   input  logic                 i_c1_present,
   input  logic [FU_NUMBER-1:0] i_busy_fu,
   output issue_sel_t           o_sel
);

   always_comb begin
      o_sel      = '0;
      o_sel.c0_v = i_c0_present && !i_busy_fu[i_c0.functional_unit];
      o_sel.c1_v = o_sel.c0_v && i_c1_present
                   && (i_c1.functional_unit != i_c0.functional_unit)
                   && !i_busy_fu[i_c1.functional_unit];
      o_sel.n    = {1'b0, o_sel.c0_v} + {1'b0, o_sel.c1_v};
   end

endmodule

// File: rtl/issue_dispatcher.sv
// In-order dual-issue queue between rename and execution with registered issue slots.
// Optional same-cycle bypass of an empty queue is enabled by defining ISSUE_BYPASS_EN.
module issue_dispatcher
   import issue_pkg::*;
#(
   parameter int DEPTH          = 8,
   parameter int FU_NUMBER      = 4,
   parameter int ROB_INDEX_BITS = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   issue_dispatcher_if.slave bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || FU_NUMBER != 4
       || ROB_INDEX_BITS != ROB_IDX_W) begin : g_cfg_check
      $error("issue_dispatcher: unsupported parameter combination");
   end

   to_execution   r_mem [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;
   to_execution   r_slot0_p1;
   to_execution   r_slot1_p1;
   logic [1:0]    r_issue_cnt_p1;

   logic          w_in_ready;
   logic          w_acc0;
   logic          w_acc1;
   logic          w_byp;
   logic [1:0]    w_enq_n;
   logic [1:0]    w_skip;
   logic [1:0]    w_pop;
   logic [1:0]    w_wr_n;
   logic [PW-1:0] w_head1;
   logic [PW-1:0] w_tail1;
   logic          w_c0_pres;
   logic          w_c1_pres;
   to_execution   w_c0;
   to_execution   w_c1;
   to_execution   w_s0;
   to_execution   w_s1;
   issue_sel_t    w_sel;

   assign w_in_ready = (r_count <= CW'(DEPTH - 2));
   assign w_acc0     = w_in_ready && bus.in_valid[0] && !bus.flush;
   assign w_acc1     = w_acc0 && bus.in_valid[1];
   assign w_enq_n    = {1'b0, w_acc0} + {1'b0, w_acc1};
   assign w_head1    = r_head + PW'(1);
   assign w_tail1    = r_tail + PW'(1);

`ifdef ISSUE_BYPASS_EN
   assign w_byp = (r_count == '0) && !bus.flush;
`else
   assign w_byp = 1'b0;
`endif

   // Stage p0: candidates come from the queue head, or from the input lanes when bypassing
   assign w_c0      = w_byp ? bus.in_data[0] : r_mem[r_head];
   assign w_c1      = w_byp ? bus.in_data[1] : r_mem[w_head1];
   assign w_c0_pres = w_byp ? w_acc0 : (r_count != '0);
   assign w_c1_pres = w_byp ? w_acc1 : (r_count >= CW'(2));

   issue_select #(
      .FU_NUMBER (FU_NUMBER)
   ) u_select (
      .i_c0         (w_c0),
      .i_c0_present (w_c0_pres),
      .i_c1         (w_c1),
      .i_c1_present (w_c1_pres),
      .i_busy_fu    (bus.busy_fu),
      .o_sel        (w_sel)
   );

   // Bypassed lanes that issue never touch the queue; the rest are written from the tail.
   assign w_pop  = w_byp ? 2'd0 : w_sel.n;
   assign w_skip = w_byp ? w_sel.n : 2'd0;
   assign w_wr_n = w_enq_n - w_skip;

   always_comb begin
      w_s0 = '0;
      w_s1 = '0;
      if (w_sel.c0_v) begin
         w_s0                 = w_c0;
         w_s0.valid           = 1'b1;
         w_s1.functional_unit = w_c0.functional_unit;
      end
      if (w_sel.c1_v) begin
         w_s1       = w_c1;
         w_s1.valid = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!bus.flush && w_wr_n != 2'd0) begin
         if (w_skip == 2'd0) begin
            r_mem[r_tail] <= bus.in_data[0];
            if (w_wr_n == 2'd2) r_mem[w_tail1] <= bus.in_data[1];
         end else begin
            r_mem[r_tail] <= bus.in_data[1];
         end
      end
   end

   // Stage p1: issue slots and queue bookkeeping
   always_ff @(posedge clk) begin
      if (!rst_n || bus.flush) begin
         r_head         <= '0;
         r_tail         <= '0;
         r_count        <= '0;
         r_slot0_p1     <= '0;
         r_slot1_p1     <= '0;
         r_issue_cnt_p1 <= '0;
      end else begin
         assert (bus.in_valid != 2'b10);
         r_head         <= r_head + PW'(w_pop);
         r_tail         <= r_tail + PW'(w_wr_n);
         r_count        <= r_count + CW'(w_enq_n) - CW'(w_sel.n);
         r_slot0_p1     <= w_s0;
         r_slot1_p1     <= w_s1;
         r_issue_cnt_p1 <= w_sel.n;
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.t_execution = {r_slot1_p1, r_slot0_p1};
   assign bus.issue_count = r_issue_cnt_p1;

endmodule

// File: tb/tb_issue_dispatcher.sv
// Randomised and directed bench for issue_dispatcher with a queue-based reference model.
module tb_issue_dispatcher;
   import issue_pkg::*;

   localparam int DEPTH = 8;
`ifdef ISSUE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif
   localparam int LAT = BYPASS ? 0 : 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   issue_dispatcher_if #(.FU_NUMBER(4)) bus ();

   issue_dispatcher #(
      .DEPTH          (DEPTH),
      .FU_NUMBER      (4),
      .ROB_INDEX_BITS (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int          total = 0;
   int          bad   = 0;
   int unsigned seq   = 0;
   to_execution q[$];
   to_execution nop = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic to_execution mk(input logic [1:0] fu);
      to_execution op;
      seq++;
      op.valid           = 1'b1;
      op.functional_unit = fu;
      op.rob_idx         = seq[2:0];
      op.payload         = seq[15:0];
      return op;
   endfunction

   // One clock of stimulus; the model decides what must appear after the edge.
   task automatic step(input logic [1:0] v, input to_execution d0, input to_execution d1,
                       input logic fl, input logic [3:0] busy);
      to_execution acc[$];
      to_execution cand[$];
      to_execution e0;
      to_execution e1;
      int n;
      bit byp;
      bus.in_valid   = v;
      bus.in_data[0] = d0;
      bus.in_data[1] = d1;
      bus.flush      = fl;
      bus.busy_fu    = busy;
      #1;
      chk("in_ready", bus.in_ready, ((DEPTH - q.size()) >= 2));
      n  = 0;
      e0 = '0;
      e1 = '0;
      if (fl) begin
         q.delete();
      end else begin
         if ((DEPTH - q.size()) >= 2) begin
            if (v[0]) acc.push_back(d0);
            if (v[0] && v[1]) acc.push_back(d1);
         end
         byp = BYPASS && (q.size() == 0);
         if (byp) cand = acc;
         else     cand = q;
         if (cand.size() >= 1 && !busy[cand[0].functional_unit]) begin
            n  = 1;
            e0 = cand[0];
         end
         if (n == 1 && cand.size() >= 2 && cand[1].functional_unit != cand[0].functional_unit
             && !busy[cand[1].functional_unit]) begin
            n  = 2;
            e1 = cand[1];
         end
         if (byp) begin
            for (int i = n; i < acc.size(); i++) q.push_back(acc[i]);
         end else begin
            repeat (n) void'(q.pop_front());
            foreach (acc[i]) q.push_back(acc[i]);
         end
      end
      @(posedge clk);
      #1;
      chk("issue_count", bus.issue_count, n);
      chk("slot0_valid", bus.t_execution[0].valid, (n >= 1));
      chk("slot1_valid", bus.t_execution[1].valid, (n == 2));
      if (n >= 1) begin
         chk("slot0_fu",  bus.t_execution[0].functional_unit, e0.functional_unit);
         chk("slot0_rob", bus.t_execution[0].rob_idx, e0.rob_idx);
         chk("slot0_pay", bus.t_execution[0].payload, e0.payload);
      end
      if (n == 2) begin
         chk("slot1_fu",  bus.t_execution[1].functional_unit, e1.functional_unit);
         chk("slot1_rob", bus.t_execution[1].rob_idx, e1.rob_idx);
         chk("slot1_pay", bus.t_execution[1].payload, e1.payload);
      end
      if (n == 1) chk("slot1_fu_forced", bus.t_execution[1].functional_unit, e0.functional_unit);
   endtask

   task automatic idle(input logic [3:0] busy);
      step(2'b00, nop, nop, 1'b0, busy);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

   initial begin
      to_execution a;
      to_execution b;
      logic [1:0]  v;
      logic [3:0]  busy;

      rst_n          = 1'b0;
      bus.in_valid   = 2'b00;
      bus.in_data    = '0;
      bus.flush      = 1'b0;
      bus.busy_fu    = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_issue_count", bus.issue_count, 0);
      chk("reset_slots", bus.t_execution, 0);
      chk("reset_in_ready", bus.in_ready, 1);
      rst_n = 1'b1;

      // INT + BR dual issue; also pins enqueue-to-issue latency
      a = mk(FU_INT);
      b = mk(FU_BR);
      step(2'b11, a, b, 1'b0, 4'h0);
      chk("t1_first_edge_count", bus.issue_count, BYPASS ? 2 : 0);
      repeat (LAT) idle(4'h0);
      chk("t1_count", bus.issue_count, 2);
      chk("t1_s0_fu", bus.t_execution[0].functional_unit, FU_INT);
      chk("t1_s1_fu", bus.t_execution[1].functional_unit, FU_BR);
      chk("t1_s0_pay", bus.t_execution[0].payload, a.payload);

      // Same-FU pair serialises
      a = mk(FU_INT);
      b = mk(FU_INT);
      step(2'b11, a, b, 1'b0, 4'h0);
      repeat (LAT) idle(4'h0);
      chk("t2_s0_pay", bus.t_execution[0].payload, a.payload);
      chk("t2_s1_valid", bus.t_execution[1].valid, 0);
      chk("t2_s1_fu", bus.t_execution[1].functional_unit, FU_INT);
      idle(4'h0);
      chk("t2_second_pay", bus.t_execution[0].payload, b.payload);
      chk("t2_second_count", bus.issue_count, 1);

      // Busy LSU head blocks everything for three cycles
      a = mk(FU_LSU);
      b = mk(FU_FPU);
      step(2'b11, a, b, 1'b0, 4'b0001);
      chk("t3_blocked0", bus.issue_count, 0);
      idle(4'b0001);
      chk("t3_blocked1", bus.issue_count, 0);
      idle(4'b0001);
      chk("t3_blocked2", bus.issue_count, 0);
      idle(4'h0);
      chk("t3_release_count", bus.issue_count, 2);
      chk("t3_s0_fu", bus.t_execution[0].functional_unit, FU_LSU);
      chk("t3_s1_fu", bus.t_execution[1].functional_unit, FU_FPU);

      // Fill to DEPTH-1, then drop to DEPTH-2
      for (int i = 0; i < 3; i++) step(2'b11, mk(FU_INT), mk(FU_INT), 1'b0, 4'hF);
      step(2'b01, mk(FU_INT), nop, 1'b0, 4'hF);
      chk("t4_full_ready", bus.in_ready, 0);
      step(2'b11, mk(FU_INT), mk(FU_INT), 1'b0, 4'hF);
      chk("t4_still_full", bus.in_ready, 0);
      idle(4'h0);
      chk("t4_pop_ready", bus.in_ready, 1);
      chk("t4_pop_count", bus.issue_count, 1);
      step(2'b00, nop, nop, 1'b1, 4'h0);
      // Steady two-in/two-out across the pointer wrap
      for (int i = 0; i < 3; i++) step(2'b11, mk(FU_INT), mk(FU_BR), 1'b0, 4'hF);
      for (int i = 0; i < 4; i++) begin
         step(2'b11, mk(FU_INT), mk(FU_BR), 1'b0, 4'h0);
         chk("t4_wrap_count", bus.issue_count, 2);
         chk("t4_wrap_ready", bus.in_ready, 1);
      end

      // Flush with five queued and a live slot
      step(2'b00, nop, nop, 1'b1, 4'h0);
      step(2'b11, mk(FU_INT), mk(FU_INT), 1'b0, 4'hF);
      step(2'b11, mk(FU_INT), mk(FU_INT), 1'b0, 4'hF);
      step(2'b01, mk(FU_INT), nop, 1'b0, 4'hF);
      step(2'b01, mk(FU_INT), nop, 1'b0, 4'h0);
      chk("t5_slot_live", bus.t_execution[0].valid, 1);
      step(2'b11, mk(FU_INT), mk(FU_BR), 1'b1, 4'h0);
      chk("t5_flush_s0", bus.t_execution[0].valid, 0);
      chk("t5_flush_s1", bus.t_execution[1].valid, 0);
      chk("t5_flush_count", bus.issue_count, 0);
      chk("t5_flush_ready", bus.in_ready, 1);
      a = mk(FU_BR);
      step(2'b01, a, nop, 1'b0, 4'h0);
      repeat (LAT) idle(4'h0);
      chk("t5_after_fu", bus.t_execution[0].functional_unit, FU_BR);
      chk("t5_after_pay", bus.t_execution[0].payload, a.payload);

      // Single op on an empty queue: valid right after the enqueue edge only with bypass
      step(2'b01, mk(FU_INT), nop, 1'b0, 4'h0);
      chk("t6_edge_n", bus.t_execution[0].valid, BYPASS);
      idle(4'h0);
      chk("t6_edge_n1", bus.t_execution[0].valid, !BYPASS);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 3))
            0:       v = 2'b00;
            1:       v = 2'b01;
            default: v = 2'b11;
         endcase
         busy = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
         step(v, mk(2'($urandom)), mk(2'($urandom)), ($urandom_range(0, 63) == 0), busy);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
